// File: rtl/and_tree_bist_pkg.sv
// Shared types and helpers for the AND-tree built-in self test.
package and_tree_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int N_IN_DEF   = 4;
  localparam int SETTLE_DEF = 1;
  localparam int N_IN_MAX   = 8;

  // Golden AND of the low n bits of v; bits at and above n are ignored.
  function automatic logic and_expect(input logic [N_IN_MAX-1:0] v, input int n);
    logic r;
    r = 1'b1;
    for (int i = 0; i < N_IN_MAX; i++) begin
      if (i < n) r = r & v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable 4-bit down-counter that stops at zero; flags when it has reached zero.
module bist_settle_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == 4'd0);

endmodule

// File: rtl/and_tree_bist.sv
// Walks every input vector through the AND tree, compares the returned result
// against the ideal AND and logs mismatch count and first failing vector.
module and_tree_bist
  import and_tree_bist_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_result,
  output logic [N_IN-1:0] o_vec,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_cnt,
  output logic [N_IN-1:0] o_first_fail
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic            tmr_load;
  logic            tmr_zero;
  logic [7:0]      vec_ext;
  logic            mismatch;

  assign vec_ext  = 8'(vec_q);
  assign mismatch = (i_result != and_expect(vec_ext, N_IN));

  bist_settle_timer u_settle_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tmr_load),
    .i_load_val (SETTLE_LD),
    .i_en       (state_q == ST_RUN),
    .o_zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    first_fail_d = first_fail_q;
    err_cnt_d    = err_cnt_q;
    done_d       = done_q;
    pass_d       = pass_q;
    tmr_load     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d      = ST_RUN;
          vec_d        = '0;
          first_fail_d = '0;
          err_cnt_d    = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          tmr_load     = 1'b1;
        end
      end
      ST_RUN: begin
        // Timer at zero means the current vector has settled: sample now.
        if (tmr_zero) begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) first_fail_d = vec_q;
          end
          if (&vec_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            vec_d    = vec_q + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      first_fail_q <= '0;
      err_cnt_q    <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      first_fail_q <= first_fail_d;
      err_cnt_q    <= err_cnt_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign o_vec        = vec_q;
  assign o_busy       = (state_q == ST_RUN);
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_first_fail = first_fail_q;

endmodule

// File: tb/tb_and_tree_bist.sv
// Scoreboard bench: two BIST instances (SETTLE=1 and SETTLE=3) driving modelled
// trees described by a 16-entry truth table (correct, stuck-at, or random faults).
module tb_and_tree_bist;

  typedef struct {
    int err;
    int ff;
    bit pass;
    int lat;
    int start_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start;
  logic [1:0]  res;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [1:0]  pass;
  logic [3:0]  vec [2];
  logic [4:0]  err [2];
  logic [3:0]  ff  [2];
  logic [15:0] lut [2];

  exp_t exp_q [2][$];
  int   tests;
  int   fails;
  int   cyc;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: enumerate all 16 vectors; the ideal tree is 1 only for 4'hF.
  function automatic exp_t model(input logic [15:0] l, input int settle);
    exp_t e;
    e.err = 0; e.ff = 0; e.pass = 1'b0; e.start_cyc = 0;
    e.lat = 16 * settle;
    for (int v = 0; v < 16; v++) begin
      bit want;
      want = (v == 15);
      if (l[v] != want) begin
        if (e.err == 0) e.ff = v;
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : 3;

    and_tree_bist #(.N_IN(4), .SETTLE(ST)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start[g]),
      .i_result     (res[g]),
      .o_vec        (vec[g]),
      .o_busy       (busy[g]),
      .o_done       (done[g]),
      .o_pass       (pass[g]),
      .o_err_cnt    (err[g]),
      .o_first_fail (ff[g])
    );

    assign res[g] = lut[g][vec[g]];

    initial begin
      bit   done_prev;
      bit   have_last;
      exp_t e;
      exp_t last;
      int   n;
      int   ev;
      done_prev = 1'b0;
      have_last = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          done_prev = 1'b0;
        end else begin
          if (done[g] && !done_prev) begin
            if (exp_q[g].size() == 0) begin
              chk("unexpected_done", 1, 0);
            end else begin
              e = exp_q[g].pop_front();
              chk("err_cnt", int'(err[g]), e.err);
              chk("first_fail", int'(ff[g]), e.ff);
              chk("pass", int'(pass[g]), int'(e.pass));
              chk("final_vec", int'(vec[g]), 15);
              chk("busy_at_done", int'(busy[g]), 0);
              chk("latency", cyc - e.start_cyc, e.lat);
              last = e;
              have_last = 1'b1;
            end
          end else if (exp_q[g].size() != 0) begin
            n  = cyc - exp_q[g][0].start_cyc;
            ev = n / ST;
            if (ev > 15) ev = 15;
            chk("vec_hold", int'(vec[g]), ev);
            chk("busy_run", int'(busy[g]), 1);
            chk("done_run", int'(done[g]), 0);
          end else if (done[g] && have_last) begin
            chk("frozen_err", int'(err[g]), last.err);
            chk("frozen_pass", int'(pass[g]), int'(last.pass));
            chk("frozen_vec", int'(vec[g]), 15);
          end
          done_prev = done[g];
        end
      end
    end
  end

  task automatic run(input int d, input logic [15:0] l, input bit poke);
    exp_t e;
    int   n;
    @(negedge clk);
    lut[d]   = l;
    start[d] = 1'b1;
    @(posedge clk);
    #1 start[d] = 1'b0;
    e = model(l, (d == 0) ? 1 : 3);
    e.start_cyc = cyc;
    exp_q[d].push_back(e);
    n = 0;
    while (!done[d] && n < e.lat + 20) begin
      @(negedge clk);
      n++;
      if (poke) start[d] = (n == 5);
    end
    start[d] = 1'b0;
    if (!done[d]) begin
      chk("run_timeout", 0, 1);
      exp_q[d].delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_vec"}, int'(vec[d]), 0);
    chk({tag, "_busy"}, int'(busy[d]), 0);
    chk({tag, "_done"}, int'(done[d]), 0);
    chk({tag, "_pass"}, int'(pass[d]), 0);
    chk({tag, "_err"}, int'(err[d]), 0);
    chk({tag, "_ff"}, int'(ff[d]), 0);
  endtask

  initial begin
    logic [15:0] l;
    int          d;
    int          sel;
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start  = 2'b00;
    lut[0] = 16'h8000;
    lut[1] = 16'h8000;
    repeat (3) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    #2 rst_n = 1'b1;

    run(0, 16'h8000, 1'b0);
    run(0, 16'h0000, 1'b0);
    run(0, 16'hFFFF, 1'b0);
    run(0, 16'h8000, 1'b1);

    // Abort a faulty run with an asynchronous reset mid-way.
    @(negedge clk);
    lut[0]   = 16'h0000;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    begin
      exp_t e;
      e = model(16'h0000, 1);
      e.start_cyc = cyc;
      exp_q[0].push_back(e);
    end
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero(0, "midrst");
    exp_q[0].delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(0, 16'h8000, 1'b0);

    run(1, 16'h8000, 1'b0);
    run(1, 16'h8000, 1'b0);
    run(1, 16'h0000, 1'b1);

    for (int i = 0; i < 8; i++) begin
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       l = 16'h8000;
        1:       l = 16'h8000 ^ (16'h1 << $urandom_range(0, 15));
        default: l = 16'($urandom);
      endcase
      run(d, l, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, failed=%0d", fails);
    $fatal(1, "watchdog expired");
  end

endmodule
